// File: rtl/ascon_pack.sv
// Shared ASCON types: 320-bit permutation state, round-constant table,
// last-round index and the permutation sequencer FSM encoding.
package ascon_pack;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;

    localparam logic [3:0] ROUND_MAX = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } type_perm_fsm;

    function automatic logic [7:0] round_constant(input logic [3:0] round);
        logic [7:0] c;
        case (round)
            4'd0:    c = 8'hf0;
            4'd1:    c = 8'he1;
            4'd2:    c = 8'hd2;
            4'd3:    c = 8'hc3;
            4'd4:    c = 8'hb4;
            4'd5:    c = 8'ha5;
            4'd6:    c = 8'h96;
            4'd7:    c = 8'h87;
            4'd8:    c = 8'h78;
            4'd9:    c = 8'h69;
            4'd10:   c = 8'h5a;
            4'd11:   c = 8'h4b;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/round_counter.sv
// 4-bit round counter: loadable, counts up when enabled, saturates at
// ROUND_MAX. Ports: clock/reset, load_i+load_value_i, enable_i, count_o, last_o.
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic [3:0] load_value_i,
    input  logic       enable_i,
    output logic [3:0] count_o,
    output logic       last_o
);

    logic [3:0] count_q;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            count_q <= 4'd0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (enable_i && (count_q != ROUND_MAX)) begin
            count_q <= count_q + 4'd1;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == ROUND_MAX);

endmodule

// File: rtl/permutation_sequencer.sv
// Iterative ASCON p^a / p^b controller: owns the state register and round
// counter, feeds the external round chain and pulses done_o on completion.
// Ports: clock_i, resetb_i, start_i, mode_i, init_state_i, round_state_i,
// state_o, round_o, busy_o, done_o, result_o.
module permutation_sequencer
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  type_state  init_state_i,
    input  type_state  round_state_i,
    output type_state  state_o,
    output logic [3:0] round_o,
    output logic       busy_o,
    output logic       done_o,
    output type_state  result_o
);

    // Shorter permutations start later in the constant table so the
    // last round always uses index 11.
    localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
    localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);

    type_perm_fsm fsm_q;
    type_perm_fsm fsm_d;
    type_state    state_q;
    logic         load;
    logic         step;
    logic         last;
    logic [3:0]   count;
    logic [3:0]   load_value;

    assign load_value = mode_i ? START_B : START_A;

    round_counter u_round_counter (
        .clock_i      (clock_i),
        .resetb_i     (resetb_i),
        .load_i       (load),
        .load_value_i (load_value),
        .enable_i     (step),
        .count_o      (count),
        .last_o       (last)
    );

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= '0;
        end else if (load) begin
            state_q <= init_state_i;
        end else if (step) begin
            state_q <= round_state_i;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        load  = 1'b0;
        step  = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    load  = 1'b1;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                // A start here chains the next permutation with no bubble.
                if (start_i) begin
                    load  = 1'b1;
                    fsm_d = RUN;
                end else begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    assign state_o  = state_q;
    assign result_o = state_q;
    assign round_o  = count;
    assign busy_o   = (fsm_q == RUN);
    assign done_o   = (fsm_q == DONE);

endmodule

// File: tb/tb_permutation_sequencer.sv
// Self-checking bench for permutation_sequencer with a stub (x2+1) round
// chain and a behavioural ASCON round chain plus reference permutation.
module tb_permutation_sequencer;
    import ascon_pack::*;

    logic       clock = 1'b0;
    logic       resetb = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    type_state  init_state = '0;
    type_state  round_state;
    type_state  state_o;
    logic [3:0] round_o;
    logic       busy;
    logic       done;
    type_state  result;
    bit         use_real = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    permutation_sequencer #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
        .clock_i       (clock),
        .resetb_i      (resetb),
        .start_i       (start),
        .mode_i        (mode),
        .init_state_i  (init_state),
        .round_state_i (round_state),
        .state_o       (state_o),
        .round_o       (round_o),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (result)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // ASCON round from the algorithm description; constant computed as
    // 0xf0 - 0x0f*r instead of looked up.
    function automatic type_state model_round(input type_state s, input int r);
        logic [63:0] x[5];
        logic [63:0] t[5];
        x[0] = s.x0; x[1] = s.x1; x[2] = s.x2; x[3] = s.x3; x[4] = s.x4;
        x[2] ^= 64'(240 - 15 * r);
        x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
        for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
        for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
        x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
        x[0] ^= rotr(x[0], 19) ^ rotr(x[0], 28);
        x[1] ^= rotr(x[1], 61) ^ rotr(x[1], 39);
        x[2] ^= rotr(x[2], 1) ^ rotr(x[2], 6);
        x[3] ^= rotr(x[3], 10) ^ rotr(x[3], 17);
        x[4] ^= rotr(x[4], 7) ^ rotr(x[4], 41);
        return '{x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic type_state model_perm(input type_state s, input int n);
        type_state v = s;
        for (int r = 12 - n; r < 12; r++) v = model_round(v, r);
        return v;
    endfunction

    function automatic type_state rand_state();
        return '{{$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}};
    endfunction

    always_comb begin
        round_state = state_o;
        if (use_real) begin
            round_state = model_round(state_o, int'(round_o));
        end else begin
            round_state.x2 = state_o.x2 + 64'd1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input type_state s, input logic m);
        start = 1'b1;
        mode = m;
        init_state = s;
        tick();
        start = 1'b0;
        mode = ~m;
        init_state = rand_state();
    endtask

    task automatic test_reset();
        #2 resetb = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || round_o !== 4'd0 ||
            state_o !== '0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b round=%0d state=%h",
                     busy, done, round_o, state_o);
        end
        tick();
        #2 resetb = 1'b1;
        tick();
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_pa();
        type_state s = rand_state();
        type_state exp;
        int bad = 0;
        use_real = 1'b0;
        s.x2 = 64'd0;
        exp = s;
        exp.x2 = 64'd12;
        load(s, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || round_o !== 4'(i)) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL pa_run: %0d bad cycles, required busy=1 round 0..11", bad);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || round_o !== 4'd11) begin
            miscompares++;
            $display("FAIL pa_done: done=%b busy=%b round=%0d required 1 0 11",
                     done, busy, round_o);
        end
        vectors++;
        if (result !== exp) begin
            miscompares++;
            $display("FAIL pa_result: got %h required %h", result, exp);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
            miscompares++;
            $display("FAIL pa_idle_hold: done=%b busy=%b result=%h", done, busy, result);
        end
    endtask

    task automatic test_pb();
        type_state s = rand_state();
        type_state exp;
        int bad = 0;
        use_real = 1'b0;
        s.x2 = 64'h100;
        exp = s;
        exp.x2 = 64'h106;
        load(s, 1'b1);
        for (int i = 6; i < 12; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || round_o !== 4'(i)) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL pb_run: %0d bad cycles, required busy=1 round 6..11", bad);
        end
        vectors++;
        if (done !== 1'b1 || result !== exp) begin
            miscompares++;
            $display("FAIL pb_result: done=%b got %h required %h", done, result, exp);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        type_state s = rand_state();
        type_state exp;
        use_real = 1'b0;
        s.x2 = 64'd0;
        exp = s;
        exp.x2 = 64'd12;
        load(s, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            start = (i >= 4 && i <= 6);
            mode = 1'b1;
            tick();
        end
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || result !== exp) begin
            miscompares++;
            $display("FAIL start_ignored: done=%b got %h required %h", done, result, exp);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        type_state a = rand_state();
        type_state b = rand_state();
        type_state ea, eb;
        use_real = 1'b0;
        ea = a; ea.x2 = a.x2 + 64'd12;
        eb = b; eb.x2 = b.x2 + 64'd12;
        load(a, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        vectors++;
        if (done !== 1'b1 || result !== ea) begin
            miscompares++;
            $display("FAIL b2b_first: done=%b got %h required %h", done, result, ea);
        end
        load(b, 1'b0);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || round_o !== 4'd0 || state_o !== b) begin
            miscompares++;
            $display("FAIL b2b_reload: busy=%b round=%0d state=%h required 1 0 %h",
                     busy, round_o, state_o, b);
        end
        for (int i = 0; i < 12; i++) tick();
        vectors++;
        if (done !== 1'b1 || result !== eb) begin
            miscompares++;
            $display("FAIL b2b_second: done=%b got %h required %h", done, result, eb);
        end
        tick();
    endtask

    task automatic test_abort();
        type_state s = rand_state();
        type_state exp;
        int bad = 0;
        use_real = 1'b0;
        load(s, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (round_o !== 4'd5 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre: round=%0d busy=%b required 5 1", round_o, busy);
        end
        #2 resetb = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || round_o !== 4'd0 ||
            state_o !== '0 || result !== '0) begin
            miscompares++;
            $display("FAIL abort_async: busy=%b done=%b round=%0d state=%h",
                     busy, done, round_o, state_o);
        end
        tick();
        #2 resetb = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: %0d cycles with done/busy set, required 0", bad);
        end
        s = rand_state();
        exp = s;
        exp.x2 = s.x2 + 64'd12;
        load(s, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        vectors++;
        if (done !== 1'b1 || result !== exp) begin
            miscompares++;
            $display("FAIL abort_restart: done=%b got %h required %h", done, result, exp);
        end
        tick();
    endtask

    task automatic test_ascon_iv();
        type_state s = '{64'h80400c0600000000, 64'd0, 64'd0, 64'd0, 64'd0};
        type_state exp = model_perm(s, 12);
        use_real = 1'b1;
        load(s, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        vectors++;
        if (done !== 1'b1 || result !== exp) begin
            miscompares++;
            $display("FAIL ascon_iv: done=%b got %h required %h", done, result, exp);
        end
        tick();
    endtask

    task automatic test_random();
        bit in_done = 1'b0;
        use_real = 1'b1;
        for (int k = 0; k < 24; k++) begin
            type_state s = rand_state();
            logic m = 1'($urandom);
            int n = m ? 6 : 12;
            int e = 0;
            type_state exp = model_perm(s, n);
            if (in_done && $urandom_range(1) == 0) begin
                tick();
                in_done = 1'b0;
            end
            load(s, m);
            vectors++;
            if (busy !== 1'b1 || round_o !== 4'(12 - n)) begin
                miscompares++;
                $display("FAIL rand_start[%0d]: busy=%b round=%0d required 1 %0d",
                         k, busy, round_o, 12 - n);
            end
            while (done !== 1'b1 && e < 20) begin
                tick();
                e++;
            end
            vectors++;
            if (e != n || result !== exp) begin
                miscompares++;
                $display("FAIL rand_perm[%0d]: latency %0d required %0d, got %h required %h",
                         k, e, n, result, exp);
            end
            in_done = 1'b1;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_pa();
        test_pb();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        test_ascon_iv();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
